// File: rtl/exc_pkg.sv
// exc_pkg: shared exception codes, controller states and default handler vector.
`default_nettype none

package exc_pkg;

    typedef enum logic [2:0] {
        EXC_INT  = 3'd0,
        EXC_PC   = 3'd1,
        EXC_ILL  = 3'd2,
        EXC_BR   = 3'd3,
        EXC_ADDR = 3'd4,
        EXC_OVF  = 3'd5
    } exc_code_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_HANDLER = 2'd2
    } exc_state_t;

    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;

    // Overflow still lets the store through; every other cause kills memory writes too.
    function automatic logic kills_mem(input exc_code_t code);
        return code != EXC_OVF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: fixed-priority selection of the exception to take this cycle.
`default_nettype none

module exc_prio_enc
    import exc_pkg::*;
(
    input  logic      fault_en,
    input  logic      irq_en,
    input  logic      pc_err,
    input  logic      illegal,
    input  logic      branch_err,
    input  logic      addr_err,
    input  logic      ovf,
    input  logic      irq_pend,
    output logic      take,
    output exc_code_t code
);

    always_comb begin
        take = 1'b1;
        code = EXC_INT;
        if (fault_en && pc_err)          code = EXC_PC;
        else if (fault_en && illegal)    code = EXC_ILL;
        else if (fault_en && branch_err) code = EXC_BR;
        else if (fault_en && addr_err)   code = EXC_ADDR;
        else if (fault_en && ovf)        code = EXC_OVF;
        else if (irq_en && irq_pend)     code = EXC_INT;
        else                             take = 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
// exc_ctrl: precise exception / interrupt controller with flush sequencing and eret.
// Optional macro EXC_IRQ_SYNC_EN adds a 2-flop synchroniser on irq_i.
`default_nettype none

module exc_ctrl
    import exc_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                NUM_IRQ      = 6,
    parameter int                FLUSH_CYCLES = 2,
    parameter logic [DATA_W-1:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  pc_i,
    input  logic               is_branch_i,
    input  logic               pc_err_i,
    input  logic               illegal_i,
    input  logic               branch_err_i,
    input  logic               addr_err_i,
    input  logic               ovf_i,
    input  logic               eret_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_mask_i,
    input  logic               reg_wr_i,
    input  logic               mem_wr_i,
    input  logic [3:0]         mem_be_i,
    output logic               reg_wr_o,
    output logic               mem_wr_o,
    output logic [3:0]         mem_be_o,
    output logic               redirect_o,
    output logic [DATA_W-1:0]  redirect_pc_o,
    output logic               flush_o,
    output logic [DATA_W-1:0]  epc_o,
    output logic [2:0]         cause_o,
    output logic [NUM_IRQ-1:0] irq_pend_o,
    output logic               bd_o,
    output logic               exl_o
);

    exc_state_t         state;
    logic [2:0]         flush_cnt;
    logic               prev_branch;
    logic [NUM_IRQ-1:0] irq_eff;
    logic               take;
    exc_code_t          code;
    logic               eret_accept;

`ifdef EXC_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] irq_s1;
    logic [NUM_IRQ-1:0] irq_s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            irq_s1 <= irq_i;
            irq_s2 <= irq_s1;
        end
    end

    assign irq_eff = irq_s2;
`else
    assign irq_eff = irq_i;
`endif

    assign irq_pend_o = irq_eff & irq_mask_i;

    // An eret outside the handler is treated as an illegal instruction.
    exc_prio_enc u_prio (
        .fault_en   (valid_i && (state != ST_FLUSH)),
        .irq_en     (valid_i && (state == ST_RUN)),
        .pc_err     (pc_err_i),
        .illegal    (illegal_i || (eret_i && !exl_o)),
        .branch_err (branch_err_i),
        .addr_err   (addr_err_i),
        .ovf        (ovf_i),
        .irq_pend   (|irq_pend_o),
        .take       (take),
        .code       (code)
    );

    assign eret_accept = (state == ST_HANDLER) && valid_i && eret_i && !take;

    always_comb begin
        reg_wr_o = reg_wr_i;
        mem_wr_o = mem_wr_i;
        mem_be_o = mem_be_i;
        if (state == ST_FLUSH || take) begin
            reg_wr_o = 1'b0;
            if (state == ST_FLUSH || kills_mem(code)) begin
                mem_wr_o = 1'b0;
                mem_be_o = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_RUN;
            flush_cnt     <= 3'd0;
            prev_branch   <= 1'b0;
            epc_o         <= '0;
            cause_o       <= 3'd0;
            bd_o          <= 1'b0;
            exl_o         <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            flush_o       <= 1'b0;
        end else begin
            redirect_o  <= 1'b0;
            // Branch history is meaningless across a flush or a redirect.
            prev_branch <= valid_i && is_branch_i && (state != ST_FLUSH)
                           && !take && !eret_accept && !redirect_o;
            case (state)
                ST_RUN, ST_HANDLER: begin
                    if (take) begin
                        cause_o <= code;
                        if (!exl_o) begin
                            bd_o  <= prev_branch;
                            epc_o <= prev_branch ? (pc_i - DATA_W'(4)) : pc_i;
                        end
                        exl_o         <= 1'b1;
                        state         <= ST_FLUSH;
                        flush_cnt     <= 3'(FLUSH_CYCLES);
                        flush_o       <= 1'b1;
                        redirect_o    <= 1'b1;
                        redirect_pc_o <= HANDLER_ADDR;
                    end else if (eret_accept) begin
                        exl_o         <= 1'b0;
                        state         <= ST_RUN;
                        redirect_o    <= 1'b1;
                        redirect_pc_o <= epc_o;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1) begin
                        flush_o <= 1'b0;
                        state   <= ST_HANDLER;
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl with a cycle-level reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_exc_ctrl;

    localparam int          FLUSH_N = 2;
    localparam logic [31:0] HADDR   = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_i = 1'b0, is_branch_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        pc_err_i = 1'b0, illegal_i = 1'b0, branch_err_i = 1'b0;
    logic        addr_err_i = 1'b0, ovf_i = 1'b0, eret_i = 1'b0;
    logic [5:0]  irq_i = '0, irq_mask_i = '0;
    logic        reg_wr_i = 1'b0, mem_wr_i = 1'b0;
    logic [3:0]  mem_be_i = '0;
    logic        reg_wr_o, mem_wr_o, redirect_o, flush_o, bd_o, exl_o;
    logic [3:0]  mem_be_o;
    logic [31:0] redirect_pc_o, epc_o;
    logic [2:0]  cause_o;
    logic [5:0]  irq_pend_o;

    always #5 clk = ~clk;

    exc_ctrl #(.DATA_W(32), .NUM_IRQ(6), .FLUSH_CYCLES(FLUSH_N), .HANDLER_ADDR(HADDR)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i), .is_branch_i(is_branch_i),
        .pc_err_i(pc_err_i), .illegal_i(illegal_i), .branch_err_i(branch_err_i),
        .addr_err_i(addr_err_i), .ovf_i(ovf_i), .eret_i(eret_i), .irq_i(irq_i),
        .irq_mask_i(irq_mask_i), .reg_wr_i(reg_wr_i), .mem_wr_i(mem_wr_i), .mem_be_i(mem_be_i),
        .reg_wr_o(reg_wr_o), .mem_wr_o(mem_wr_o), .mem_be_o(mem_be_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .flush_o(flush_o), .epc_o(epc_o), .cause_o(cause_o),
        .irq_pend_o(irq_pend_o), .bd_o(bd_o), .exl_o(exl_o)
    );

    typedef struct {
        logic rst_n, valid, br, pc_err, ill, br_err, addr_err, ovf, eret, reg_wr, mem_wr;
        logic [31:0] pc;
        logic [5:0] irq, mask;
        logic [3:0] be;
    } stim_t;

    typedef struct {
        int cyc;
        logic reg_wr, mem_wr, flush, exl, bd;
        logic [3:0] be;
        logic [5:0] pend;
        logic [2:0] cause;
        logic [31:0] epc;
    } comb_t;

    typedef struct {
        int due;
        logic exc, bd;
        logic [31:0] pc, epc;
        logic [2:0] cause;
    } redir_t;

    comb_t  cq[$];
    redir_t rq[$];
    comb_t  me;
    redir_t mr;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: mode 0 = running, 1 = flushing, 2 = in handler.
    int          m_mode = 0, m_left = 0;
    logic        m_exl = 0, m_bd = 0, m_prev = 0, m_redir = 0;
    logic [2:0]  m_cause = 0;
    logic [31:0] m_epc = 0;
    logic [5:0]  h0 = 0, h1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
            me = cq.pop_front();
            chk("reg_wr_o", reg_wr_o, me.reg_wr);
            chk("mem_wr_o", mem_wr_o, me.mem_wr);
            chk("mem_be_o", mem_be_o, me.be);
            chk("irq_pend_o", irq_pend_o, me.pend);
            chk("flush_o", flush_o, me.flush);
            chk("exl_o", exl_o, me.exl);
            chk("cause_o", cause_o, me.cause);
            chk("epc_o", epc_o, me.epc);
            chk("bd_o", bd_o, me.bd);
        end
        if (redirect_o) begin
            if (rq.size() == 0 || rq[0].due != cyc) begin
                checks++; errors++;
                $display("FAIL unexpected_redirect: got redirect to %h expected none (cycle %0d)",
                         redirect_pc_o, cyc);
            end else begin
                mr = rq.pop_front();
                chk("redirect_pc_o", redirect_pc_o, mr.pc);
                chk("redirect_flush", flush_o, mr.exc);
                if (mr.exc) begin
                    chk("redirect_cause", cause_o, mr.cause);
                    chk("redirect_epc", epc_o, mr.epc);
                    chk("redirect_bd", bd_o, mr.bd);
                end
            end
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL missing_redirect: got none expected redirect to %h (cycle %0d)",
                     rq[0].pc, cyc);
            void'(rq.pop_front());
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1; s.valid = 0; s.br = 0; s.pc_err = 0; s.ill = 0; s.br_err = 0;
        s.addr_err = 0; s.ovf = 0; s.eret = 0; s.reg_wr = 0; s.mem_wr = 0;
        s.pc = '0; s.irq = '0; s.mask = '0; s.be = '0;
        return s;
    endfunction

    // Drive one cycle and let the model predict this cycle's outputs and any redirect.
    task automatic go(input stim_t s);
        logic [5:0] pend;
        logic fault, irqt, take, eacc, np, ill_eff;
        logic [2:0] code;
        comb_t e;
        redir_t r;
        @(posedge clk); #1;
        reset = s.rst_n; valid_i = s.valid; pc_i = s.pc; is_branch_i = s.br;
        pc_err_i = s.pc_err; illegal_i = s.ill; branch_err_i = s.br_err;
        addr_err_i = s.addr_err; ovf_i = s.ovf; eret_i = s.eret; irq_i = s.irq;
        irq_mask_i = s.mask; reg_wr_i = s.reg_wr; mem_wr_i = s.mem_wr; mem_be_i = s.be;
        if (!s.rst_n) begin
            m_mode = 0; m_left = 0; m_exl = 0; m_bd = 0; m_prev = 0; m_redir = 0;
            m_cause = 0; m_epc = 0; h0 = 0; h1 = 0;
            return;
        end
`ifdef EXC_IRQ_SYNC_EN
        pend = h1 & s.mask;
`else
        pend = s.irq & s.mask;
`endif
        ill_eff = s.ill || (s.eret && !m_exl);
        fault = s.valid && m_mode != 1 &&
                (s.pc_err || ill_eff || s.br_err || s.addr_err || s.ovf);
        irqt = s.valid && m_mode == 0 && pend != 0;
        take = fault || irqt;
        if (!fault)          code = 0;
        else if (s.pc_err)   code = 1;
        else if (ill_eff)    code = 2;
        else if (s.br_err)   code = 3;
        else if (s.addr_err) code = 4;
        else                 code = 5;

        e.cyc = cyc; e.pend = pend; e.flush = (m_mode == 1); e.exl = m_exl;
        e.cause = m_cause; e.epc = m_epc; e.bd = m_bd;
        e.reg_wr = s.reg_wr; e.mem_wr = s.mem_wr; e.be = s.be;
        if (m_mode == 1 || take) e.reg_wr = 0;
        if (m_mode == 1 || (take && code != 5)) begin e.mem_wr = 0; e.be = 0; end
        cq.push_back(e);

        eacc = m_mode == 2 && s.valid && s.eret && !fault;
        np = s.valid && s.br && m_mode != 1 && !take && !eacc && !m_redir;
        m_redir = 0;
        if (m_mode != 1 && take) begin
            if (!m_exl) begin
                m_bd = m_prev;
                m_epc = m_prev ? s.pc - 32'd4 : s.pc;
            end
            m_cause = code; m_exl = 1; m_mode = 1; m_left = FLUSH_N; m_redir = 1;
            r.due = cyc + 1; r.exc = 1; r.pc = HADDR; r.epc = m_epc; r.cause = code; r.bd = m_bd;
            rq.push_back(r);
        end else if (eacc) begin
            r.due = cyc + 1; r.exc = 0; r.pc = m_epc; r.epc = m_epc; r.cause = m_cause; r.bd = m_bd;
            rq.push_back(r);
            m_exl = 0; m_mode = 0; m_redir = 1;
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end
        m_prev = np;
        h1 = h0; h0 = s.irq;
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) go(idle());
    endtask

    task automatic do_eret(input logic [31:0] pc);
        stim_t s = idle();
        s.valid = 1; s.eret = 1; s.pc = pc;
        go(s);
    endtask

    initial begin
        stim_t s;
        s = idle(); s.rst_n = 0;
        go(s); go(s);
        go(idle());
        chk("reset_redirect_pc", redirect_pc_o, 32'h0);
        chk("reset_redirect", redirect_o, 1'b0);

        // Illegal instruction kills both writes and redirects to the handler.
        s = idle(); s.valid = 1; s.pc = 32'h100; s.ill = 1; s.reg_wr = 1; s.mem_wr = 1; s.be = 4'hF;
        go(s);
        go(idle());
        chk("ill_cause", cause_o, 32'd2);
        chk("ill_epc", epc_o, 32'h100);
        chk("ill_redirect_pc", redirect_pc_o, HADDR);
        idles(3);
        do_eret(32'h4190);
        go(idle());
        chk("eret_redirect_pc", redirect_pc_o, 32'h100);
        chk("eret_exl", exl_o, 1'b0);

        // Delay slot fault, then a nested overflow inside the handler.
        s = idle(); s.valid = 1; s.pc = 32'h200; s.br = 1; go(s);
        s = idle(); s.valid = 1; s.pc = 32'h204; s.addr_err = 1; s.reg_wr = 1; go(s);
        go(idle());
        chk("ds_epc", epc_o, 32'h200);
        chk("ds_bd", bd_o, 1'b1);
        chk("ds_cause", cause_o, 32'd4);
        idles(3);
        s = idle(); s.valid = 1; s.pc = 32'h4188; s.ovf = 1; s.mem_wr = 1; s.reg_wr = 1; s.be = 4'h3;
        go(s);
        go(idle());
        chk("nested_epc", epc_o, 32'h200);
        chk("nested_cause", cause_o, 32'd5);
        idles(3);
        do_eret(32'h4190);
        go(idle());
        chk("nested_eret_pc", redirect_pc_o, 32'h200);

        // Overflow from the running state lets the store through.
        s = idle(); s.valid = 1; s.pc = 32'h300; s.ovf = 1; s.mem_wr = 1; s.reg_wr = 1; s.be = 4'hC;
        go(s);
        idles(4);
        do_eret(32'h4190);
        go(idle());

        // Masked interrupt ignored; enabled interrupt taken after its latency.
        s = idle(); s.valid = 1; s.irq = 6'b000100;
        go(s); go(s); go(s);
        s = idle(); s.valid = 1; s.mask = 6'b000100;
        go(s); go(s);
        s.irq = 6'b000100;
        go(s); go(s); go(s);
        idles(6);
        chk("irq_cause", cause_o, 32'd0);
        do_eret(32'h4190);
        go(idle());

        // pc_err outranks a pending interrupt in the same cycle.
        s = idle(); s.valid = 1; s.pc = 32'h500; s.pc_err = 1; s.irq = 6'b000100; s.mask = 6'b000100;
        go(s);
        go(idle());
        chk("prio_cause", cause_o, 32'd1);
        idles(6);
        do_eret(32'h4190);
        go(idle());

        // eret outside the handler is illegal.
        do_eret(32'h700);
        go(idle());
        chk("eret_run_cause", cause_o, 32'd2);
        chk("eret_run_epc", epc_o, 32'h700);
        idles(3);
        do_eret(32'h4190);
        go(idle());

        // Reset in the middle of the flush window.
        s = idle(); s.valid = 1; s.pc = 32'h600; s.br_err = 1; go(s);
        go(idle());
        s = idle(); s.rst_n = 0; go(s);
        go(idle());
        chk("rst_flush", flush_o, 1'b0);
        chk("rst_exl", exl_o, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            s = idle();
            s.valid    = ($urandom_range(0, 7) != 0);
            s.pc       = $urandom & 32'hFFFF_FFFC;
            s.br       = ($urandom_range(0, 3) == 0);
            s.pc_err   = ($urandom_range(0, 31) == 0);
            s.ill      = ($urandom_range(0, 23) == 0);
            s.br_err   = ($urandom_range(0, 31) == 0);
            s.addr_err = ($urandom_range(0, 15) == 0);
            s.ovf      = ($urandom_range(0, 15) == 0);
            s.eret     = ($urandom_range(0, 5) == 0);
            s.irq      = 6'($urandom);
            s.mask     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            s.reg_wr   = 1'($urandom);
            s.mem_wr   = 1'($urandom);
            s.be       = 4'($urandom);
            go(s);
        end
        idles(4);
        @(posedge clk); #1;
        checks++;
        if (rq.size() != 0) begin
            errors++;
            $display("FAIL redirect_queue: got %0d outstanding expected 0", rq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
